// File: rtl/memory_controller_mp_if.sv
// Request/response bus of memory_controller_mp, per-port fields flattened with
// port p at [p*W +: W]. master = requester side, slave = controller side.
interface memory_controller_mp_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int PORTS  = 2
);
    logic [PORTS-1:0]        rqst_valid;
    logic [PORTS-1:0]        rqst_ready;
    logic [PORTS-1:0]        rqst_we;
    logic [PORTS*ADDR_W-1:0] rqst_address;
    logic [PORTS*DATA_W-1:0] rqst_data;
    logic [PORTS-1:0]        ret_ack;
    logic [PORTS-1:0]        ret_we;
    logic [PORTS*ADDR_W-1:0] ret_address;
    logic [PORTS*DATA_W-1:0] ret_data;

    modport master (
        output rqst_valid, rqst_we, rqst_address, rqst_data,
        input  rqst_ready, ret_ack, ret_we, ret_address, ret_data
    );

    modport slave (
        input  rqst_valid, rqst_we, rqst_address, rqst_data,
        output rqst_ready, ret_ack, ret_we, ret_address, ret_data
    );
endinterface

// File: rtl/memory_controller_mp.sv
// Multi-port memory model: per-port request FIFOs, round-robin single issue per
// cycle, fixed-latency address-tagged responses. Define MEMCTL_STATS_EN for counters.
module memory_controller_mp #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int PORTS      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    memory_controller_mp_if.slave bus
`ifdef MEMCTL_STATS_EN
    ,
    output logic [31:0]           stat_rd_count,
    output logic [31:0]           stat_wr_count,
    output logic [31:0]           stat_stall_count
`endif
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_t;

    req_t                    fifo_mem_q [PORTS][FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_q [PORTS];
    logic [PTR_W:0]          wr_ptr_d [PORTS];
    logic [PTR_W:0]          rd_ptr_q [PORTS];
    logic [PTR_W:0]          rd_ptr_d [PORTS];
    logic [PORTS-1:0]        full, empty, push;
    logic [PORT_W-1:0]       rr_q, rr_d, grant, cand;
    logic                    grant_vld;
    req_t                    head;
    logic [IDX_W-1:0]        idx;
    rsp_t                    issue, tail;
    rsp_t                    pipe_q [PIPE_N];
    rsp_t                    pipe_d [PIPE_N];
    logic [DATA_W-1:0]       mem_q [MEM_WORDS];
    logic [PORTS-1:0]        ret_ack_q, ret_ack_d, ret_we_q, ret_we_d;
    logic [PORTS*ADDR_W-1:0] ret_address_q, ret_address_d;
    logic [PORTS*DATA_W-1:0] ret_data_q, ret_data_d;

    // Full when indices match but the wrap bits differ.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            full[p]  = (wr_ptr_q[p][PTR_W-1:0] == rd_ptr_q[p][PTR_W-1:0]) &&
                       (wr_ptr_q[p][PTR_W] != rd_ptr_q[p][PTR_W]);
            push[p]  = bus.rqst_valid[p] && !full[p];
        end
    end

    assign bus.rqst_ready = ~full;

    // NOTE: every variable gets a default before any branch so no path infers a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = PORT_W'((int'(rr_q) + i) % PORTS);
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end

        head        = fifo_mem_q[grant][rd_ptr_q[grant][PTR_W-1:0]];
        idx         = head.addr[IDX_W-1:0];
        issue.valid = grant_vld;
        issue.port  = grant;
        issue.we    = head.we;
        issue.addr  = head.addr;
        issue.data  = head.we ? '0 : mem_q[idx];

        rr_d = rr_q;
        if (grant_vld) rr_d = (grant == PORT_W'(PORTS - 1)) ? '0 : grant + 1'b1;

        for (int p = 0; p < PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + (PTR_W + 1)'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + (PTR_W + 1)'(grant_vld && (grant == PORT_W'(p)));
        end
    end

    // The per-port output registers form the final latency stage.
    always_comb begin
        pipe_d[0] = issue;
        for (int i = 1; i < PIPE_N; i++) pipe_d[i] = pipe_q[i-1];
        tail = (LATENCY == 1) ? issue : pipe_q[PIPE_N-1];

        ret_ack_d     = '0;
        ret_we_d      = ret_we_q;
        ret_address_d = ret_address_q;
        ret_data_d    = ret_data_q;
        if (tail.valid) begin
            ret_ack_d[tail.port]                        = 1'b1;
            ret_we_d[tail.port]                         = tail.we;
            ret_address_d[tail.port*ADDR_W +: ADDR_W]   = tail.addr;
            ret_data_d[tail.port*DATA_W +: DATA_W]      = tail.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
            for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
            rr_q          <= '0;
            ret_ack_q     <= '0;
            ret_we_q      <= '0;
            ret_address_q <= '0;
            ret_data_q    <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
            end
            for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= pipe_d[i];
            rr_q          <= rr_d;
            ret_ack_q     <= ret_ack_d;
            ret_we_q      <= ret_we_d;
            ret_address_q <= ret_address_d;
            ret_data_q    <= ret_data_d;
        end
    end

    // NOTE: storage arrays are not reset; pointers and pipeline valids alone say what is live.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (push[p]) begin
                fifo_mem_q[p][wr_ptr_q[p][PTR_W-1:0]] <= {bus.rqst_we[p],
                    bus.rqst_address[p*ADDR_W +: ADDR_W], bus.rqst_data[p*DATA_W +: DATA_W]};
            end
        end
        if (!reset && grant_vld && head.we) mem_q[idx] <= head.data;
    end

    assign bus.ret_ack     = ret_ack_q;
    assign bus.ret_we      = ret_we_q;
    assign bus.ret_address = ret_address_q;
    assign bus.ret_data    = ret_data_q;

`ifdef MEMCTL_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        rd_cnt_d    = rd_cnt_q + 32'(grant_vld && !head.we);
        wr_cnt_d    = wr_cnt_q + 32'(grant_vld && head.we);
        stall_cnt_d = stall_cnt_q + 32'(|(bus.rqst_valid & full));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_rd_count    = rd_cnt_q;
    assign stat_wr_count    = wr_cnt_q;
    assign stat_stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_memory_controller_mp.sv
// Bench for memory_controller_mp: directed scenarios plus randomized traffic, all
// compared each cycle against a queue-based behavioural model of the controller.
module tb_memory_controller_mp;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int PORTS      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_WORDS  = 1024;
    localparam int LATENCY    = 4;
    localparam int VEC_W      = PORTS * (3 + ADDR_W + DATA_W);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    memory_controller_mp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PORTS(PORTS)) bus ();

`ifdef MEMCTL_STATS_EN
    logic [31:0] stat_rd_count, stat_wr_count, stat_stall_count;
`endif

    memory_controller_mp #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PORTS(PORTS),
        .FIFO_DEPTH(FIFO_DEPTH), .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef MEMCTL_STATS_EN
        ,
        .stat_rd_count(stat_rd_count),
        .stat_wr_count(stat_wr_count),
        .stat_stall_count(stat_stall_count)
`endif
    );

    typedef struct {
        bit              we;
        bit [ADDR_W-1:0] addr;
        bit [DATA_W-1:0] data;
    } req_s;

    typedef struct {
        int              due;
        int              port;
        bit              we;
        bit [ADDR_W-1:0] addr;
        bit [DATA_W-1:0] data;
        bit              known;
    } rsp_s;

    // Reference model state
    req_s                  mq [PORTS][$];
    rsp_s                  inflight [$];
    bit [DATA_W-1:0]       mmem [MEM_WORDS];
    bit                    mknown [MEM_WORDS];
    int                    rr;
    int                    cyc;
    bit [PORTS-1:0]        m_ack, m_we, m_known;
    bit [PORTS*ADDR_W-1:0] m_addr;
    bit [PORTS*DATA_W-1:0] m_data;
    int unsigned           m_rd, m_wr, m_stall;

    int passed = 0;
    int total  = 0;

    task automatic drive(input int p, input bit v, input bit we,
                         input bit [ADDR_W-1:0] a, input bit [DATA_W-1:0] d);
        bus.rqst_valid[p]                    = v;
        bus.rqst_we[p]                       = we;
        bus.rqst_address[p*ADDR_W +: ADDR_W] = a;
        bus.rqst_data[p*DATA_W +: DATA_W]    = d;
    endtask

    task automatic idle();
        bus.rqst_valid = '0;
    endtask

    // One clock edge: DUT advances, model applies the same edge from the spec rules.
    task automatic tick();
        bit [PORTS-1:0] rdy;
        bit             granted;
        int             p;
        int             idx;
        req_s           r;
        rsp_s           s;
        for (int q = 0; q < PORTS; q++) rdy[q] = (mq[q].size() < FIFO_DEPTH);
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int q = 0; q < PORTS; q++) mq[q].delete();
            inflight.delete();
            rr = 0;
            m_ack = '0; m_we = '0; m_addr = '0; m_data = '0; m_known = '1;
            m_rd = 0; m_wr = 0; m_stall = 0;
        end else begin
            if (|(bus.rqst_valid & ~rdy)) m_stall++;
            granted = 1'b0;
            for (int i = 0; i < PORTS; i++) begin
                p = (rr + i) % PORTS;
                if (!granted && mq[p].size() != 0) begin
                    granted = 1'b1;
                    r       = mq[p].pop_front();
                    idx     = int'(r.addr) % MEM_WORDS;
                    s.due   = cyc + LATENCY - 1;
                    s.port  = p;
                    s.we    = r.we;
                    s.addr  = r.addr;
                    if (r.we) begin
                        mmem[idx] = r.data; mknown[idx] = 1'b1;
                        s.data = '0; s.known = 1'b1; m_wr++;
                    end else begin
                        s.data = mmem[idx]; s.known = mknown[idx]; m_rd++;
                    end
                    inflight.push_back(s);
                    rr = (p + 1) % PORTS;
                end
            end
            for (int q = 0; q < PORTS; q++) begin
                if (bus.rqst_valid[q] && rdy[q]) begin
                    r.we   = bus.rqst_we[q];
                    r.addr = bus.rqst_address[q*ADDR_W +: ADDR_W];
                    r.data = bus.rqst_data[q*DATA_W +: DATA_W];
                    mq[q].push_back(r);
                end
            end
            m_ack = '0;
            while (inflight.size() != 0 && inflight[0].due == cyc) begin
                s = inflight.pop_front();
                m_ack[s.port]                      = 1'b1;
                m_we[s.port]                       = s.we;
                m_addr[s.port*ADDR_W +: ADDR_W]    = s.addr;
                m_data[s.port*DATA_W +: DATA_W]    = s.data;
                m_known[s.port]                    = s.known;
            end
        end
        #1;
    endtask

    function automatic logic [PORTS*DATA_W-1:0] dmask();
        for (int p = 0; p < PORTS; p++) dmask[p*DATA_W +: DATA_W] = {DATA_W{m_known[p]}};
    endfunction

    function automatic logic [VEC_W-1:0] model_vec();
        logic [PORTS-1:0] rdy;
        for (int p = 0; p < PORTS; p++) rdy[p] = (mq[p].size() < FIFO_DEPTH);
        return {rdy, m_ack, m_we, m_addr, m_data & dmask()};
    endfunction

    function automatic logic [VEC_W-1:0] dut_vec();
        return {bus.rqst_ready, bus.ret_ack, bus.ret_we, bus.ret_address, bus.ret_data & dmask()};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    // One request on an idle port, then watch a bounded window for its ack.
    task automatic run_one(input string name, input int p, input bit we,
                           input bit [ADDR_W-1:0] a, input bit [DATA_W-1:0] d,
                           output int lat, output logic rwe,
                           output logic [ADDR_W-1:0] raddr, output logic [DATA_W-1:0] rdata);
        lat = -1; rwe = 1'bx; raddr = 'x; rdata = 'x;
        drive(p, 1'b1, we, a, d);
        tick();
        idle();
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL %s cycle %0d: dut=%h model=%h", name, cyc, dut_vec(), model_vec());
            else passed++;
            if (lat < 0 && bus.ret_ack[p] === 1'b1) begin
                lat   = k;
                rwe   = bus.ret_we[p];
                raddr = bus.ret_address[p*ADDR_W +: ADDR_W];
                rdata = bus.ret_data[p*DATA_W +: DATA_W];
            end
        end
    endtask

    task automatic test_reset();
        logic [VEC_W-1:0] exp_v;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        exp_v = '0;
        exp_v[VEC_W-1 -: PORTS] = '1;
        total++;
        if (dut_vec() !== exp_v) $display("FAIL reset_state: dut=%h want=%h", dut_vec(), exp_v);
        else passed++;
    endtask

    task automatic test_write_read();
        int lat; logic rwe; logic [ADDR_W-1:0] ra; logic [DATA_W-1:0] rd;
        run_one("write_0010", 0, 1'b1, 16'h0010, 16'h1234, lat, rwe, ra, rd);
        total++;
        if ({lat, rwe, ra, rd} !== {LATENCY, 1'b1, 16'h0010, 16'h0000})
            $display("FAIL write_ack: lat=%0d we=%b addr=%h data=%h want lat=%0d we=1 addr=0010 data=0000",
                     lat, rwe, ra, rd, LATENCY);
        else passed++;
        run_one("read_0010", 0, 1'b0, 16'h0010, 16'h0, lat, rwe, ra, rd);
        total++;
        if ({lat, rwe, ra, rd} !== {LATENCY, 1'b0, 16'h0010, 16'h1234})
            $display("FAIL read_ack: lat=%0d we=%b addr=%h data=%h want lat=%0d we=0 addr=0010 data=1234",
                     lat, rwe, ra, rd, LATENCY);
        else passed++;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            for (int p = 0; p < PORTS; p++)
                drive(p, 1'b1, 1'b1, 16'(16'h0020 + p * 16 + i), 16'($urandom));
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL alternate cycle %0d: dut=%h model=%h", cyc, dut_vec(), model_vec());
            else passed++;
            if (i >= 5) begin
                total++;
                if (bus.ret_ack !== ((i % 2 == 1) ? 2'b01 : 2'b10))
                    $display("FAIL alternate_ack step %0d: ack=%b want=%b", i, bus.ret_ack,
                             (i % 2 == 1) ? 2'b01 : 2'b10);
                else passed++;
            end
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL alternate_drain cycle %0d: dut=%h model=%h", cyc, dut_vec(), model_vec());
            else passed++;
        end
    endtask

    task automatic test_full_queue();
        bit seen_low = 1'b0;
        bit seen_rise = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < PORTS; p++)
                drive(p, 1'b1, 1'b1, 16'(16'h0040 + p * 32 + i), 16'($urandom));
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL full_queue cycle %0d: dut=%h model=%h", cyc, dut_vec(), model_vec());
            else passed++;
            if (bus.rqst_ready[0] === 1'b0) seen_low = 1'b1;
            else if (seen_low) seen_rise = 1'b1;
        end
        total++;
        if (!(seen_low && seen_rise))
            $display("FAIL full_queue_ready: low_seen=%b rise_seen=%b want 1 1", seen_low, seen_rise);
        else passed++;
`ifdef MEMCTL_STATS_EN
        total++;
        if (stat_stall_count !== m_stall || m_stall == 0)
            $display("FAIL stall_count: dut=%0d model=%0d", stat_stall_count, m_stall);
        else passed++;
`endif
        idle();
        for (int i = 0; i < 24; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL full_drain cycle %0d: dut=%h model=%h", cyc, dut_vec(), model_vec());
            else passed++;
        end
    endtask

    task automatic test_alias();
        int lat; logic rwe; logic [ADDR_W-1:0] ra; logic [DATA_W-1:0] rd;
        run_one("alias_write", 1, 1'b1, 16'h0405, 16'hBEEF, lat, rwe, ra, rd);
        run_one("alias_read", 1, 1'b0, 16'h0005, 16'h0, lat, rwe, ra, rd);
        total++;
        if ({lat, ra, rd} !== {LATENCY, 16'h0005, 16'hBEEF})
            $display("FAIL alias: lat=%0d addr=%h data=%h want lat=%0d addr=0005 data=BEEF",
                     lat, ra, rd, LATENCY);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [VEC_W-1:0] exp_v;
        bit any_ack = 1'b0;
        int lat; logic rwe; logic [ADDR_W-1:0] ra; logic [DATA_W-1:0] rd;
        drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        tick();
        drive(0, 1'b1, 1'b0, 16'h0405, 16'h0);
        tick();
        drive(0, 1'b1, 1'b0, 16'h0005, 16'h0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_v = '0;
        exp_v[VEC_W-1 -: PORTS] = '1;
        total++;
        if (dut_vec() !== exp_v) $display("FAIL mid_reset_state: dut=%h want=%h", dut_vec(), exp_v);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ret_ack !== 2'b00) any_ack = 1'b1;
        end
        total++;
        if (any_ack) $display("FAIL mid_reset_no_ack: ack seen=1 want=0");
        else passed++;
        run_one("post_reset_read", 0, 1'b0, 16'h0010, 16'h0, lat, rwe, ra, rd);
        total++;
        if ({lat, ra, rd} !== {LATENCY, 16'h0010, 16'h1234})
            $display("FAIL post_reset_read: lat=%0d addr=%h data=%h want lat=%0d addr=0010 data=1234",
                     lat, ra, rd, LATENCY);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < PORTS; p++)
                drive(p, $urandom_range(0, 3) != 0, 1'($urandom),
                      {6'($urandom), 10'($urandom_range(0, 15))}, 16'($urandom));
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL random cycle %0d: dut=%h model=%h", cyc, dut_vec(), model_vec());
            else passed++;
        end
        idle();
        for (int i = 0; i < 24; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec())
                $display("FAIL random_drain cycle %0d: dut=%h model=%h", cyc, dut_vec(), model_vec());
            else passed++;
        end
`ifdef MEMCTL_STATS_EN
        total++;
        if ({stat_rd_count, stat_wr_count, stat_stall_count} !== {m_rd, m_wr, m_stall})
            $display("FAIL stats: dut rd=%0d wr=%0d stall=%0d model rd=%0d wr=%0d stall=%0d",
                     stat_rd_count, stat_wr_count, stat_stall_count, m_rd, m_wr, m_stall);
        else passed++;
`endif
    endtask

    initial begin
        bus.rqst_valid   = '0;
        bus.rqst_we      = '0;
        bus.rqst_address = '0;
        bus.rqst_data    = '0;
        test_reset();
        test_write_read();
        test_alternate();
        test_full_queue();
        test_alias();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
